// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mips_mem_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;
    localparam int IDX_MAX_W   = 30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                 err;
        logic [IDX_MAX_W-1:0] idx;
    } addr_chk_t;

    // Word index plus misaligned / out-of-range flag for a byte address.
    function automatic addr_chk_t addr_check(input logic [31:0] addr, input int addr_w);
        addr_chk_t r;
        r.idx = IDX_MAX_W'((addr >> 2) & ((32'd1 << addr_w) - 32'd1));
        r.err = (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one synchronous read port, no reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    // Write and read ports; the read register holds until the next read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage load/store port with configurable latency.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | ready for a request; req_ready=1
//   ST_WAIT | request captured, latency counter running down
//   ST_RESP | access done, response held until rsp_ready
//
// The access executes on the edge that enters ST_RESP. Load data comes from
// the array's read register, which is only refreshed on that edge, so it stays
// stable through ST_RESP and after returning to idle. rsp_load_q gates it to
// zero for stores, errors and after reset (the array itself has no reset).
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    parameter  int LATENCY     = 2,
    localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dmem_responder: LATENCY %0d outside legal range", LATENCY);
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS %0d must be a power of two >= 4", DEPTH_WORDS);
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             wr_q,       wr_d;
    logic [31:0]      addr_q,     addr_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic             rsp_err_q,  rsp_err_d;
    logic             rsp_load_q, rsp_load_d;

    logic             enter_resp;
    logic             acc_wr;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    addr_chk_t        acc_chk;
    logic [ADDR_W-1:0] acc_idx;
    logic             unused_idx_hi;
    logic             arr_wr_en;
    logic             arr_rd_en;
    logic [31:0]      arr_rd_data;

    // With LATENCY==1 the access happens on the acceptance edge, so the live
    // request is used in idle and the captured copy otherwise.
    always_comb begin
        acc_wr    = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            acc_wr    = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign acc_chk       = addr_check(acc_addr, ADDR_W);
    assign acc_idx       = acc_chk.idx[ADDR_W-1:0];
    assign unused_idx_hi = ^acc_chk.idx[IDX_MAX_W-1:ADDR_W];

    // Next-state, counter, capture and response-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_err_d  = rsp_err_q;
        rsp_load_d = rsp_load_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    cnt_d      = '0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (enter_resp) begin
            rsp_err_d  = acc_chk.err;
            rsp_load_d = !acc_wr && !acc_chk.err;
        end
    end

    // State and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_err_q  <= rsp_err_d;
            rsp_load_q <= rsp_load_d;
        end
    end

    assign arr_wr_en = enter_resp && acc_wr && !acc_chk.err;
    assign arr_rd_en = enter_resp && !acc_wr && !acc_chk.err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_addr (acc_idx),
        .wr_data (acc_wdata),
        .rd_en   (arr_rd_en),
        .rd_addr (acc_idx),
        .rd_data (arr_rd_data)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? arr_rd_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances at LATENCY 2, 1, 15 and 4,
// directed scenarios plus random traffic against a word-array reference model.
module tb_dmem_responder;

    localparam int N = 4;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 15;
            default: return 4;
        endcase
    endfunction

    logic        clk;
    logic        rst_n     [N];
    logic        req_valid [N];
    logic        req_write [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic        req_ready [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];
    logic        busy      [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (256),
            .LATENCY     (lat_of(g))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .req_valid (req_valid[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_ready (req_ready[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    int tests = 0;
    int fails = 0;

    logic [31:0] model [N][256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance g, checked against the reference model.
    task automatic txn(input int g, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
        bit          exp_err;
        int          idx;
        logic [31:0] exp_rd;
        int          c;
        exp_err = (a[1:0] != 2'b00) || (a >= 32'd1024);
        idx     = int'(a[9:2]);
        exp_rd  = (wr || exp_err) ? 32'd0 : model[g][idx];

        check("idle_req_ready", 32'(req_ready[g]), 32'd1);
        req_valid[g] = 1'b1;
        req_write[g] = wr;
        req_addr[g]  = a;
        req_wdata[g] = wd;
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        req_write[g] = 1'($urandom);
        req_addr[g]  = $urandom;
        req_wdata[g] = $urandom;

        c = 1;
        while (!rsp_valid[g] && c < 40) begin
            check("wait_req_ready", 32'(req_ready[g]), 32'd0);
            check("wait_busy", 32'(busy[g]), 32'd1);
            @(posedge clk); #1;
            c++;
        end
        check("latency", 32'(c), 32'(lat_of(g)));
        check("rsp_rdata", rsp_rdata[g], exp_rd);
        check("rsp_err", 32'(rsp_err[g]), 32'(exp_err));
        check("resp_busy", 32'(busy[g]), 32'd1);
        check("resp_req_ready", 32'(req_ready[g]), 32'd0);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid[g]), 32'd1);
            check("hold_rdata", rsp_rdata[g], exp_rd);
            check("hold_err", 32'(rsp_err[g]), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready[g]), 32'd0);
        end

        rsp_ready[g] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[g] = 1'b0;
        check("post_valid", 32'(rsp_valid[g]), 32'd0);
        check("post_req_ready", 32'(req_ready[g]), 32'd1);
        check("post_busy", 32'(busy[g]), 32'd0);
        check("post_rdata", rsp_rdata[g], exp_rd);
        check("post_err", 32'(rsp_err[g]), 32'(exp_err));

        if (wr && !exp_err) begin
            model[g][idx] = wd;
        end
    endtask

    initial begin
        logic [31:0] a;
        int          r;

        for (int g = 0; g < N; g++) begin
            rst_n[g]     = 1'b0;
            req_valid[g] = 1'b0;
            req_write[g] = 1'b0;
            req_addr[g]  = '0;
            req_wdata[g] = '0;
            rsp_ready[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) rst_n[g] = 1'b1;
        #1;
        for (int g = 0; g < N; g++) begin
            check("rst_req_ready", 32'(req_ready[g]), 32'd1);
            check("rst_busy", 32'(busy[g]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[g]), 32'd0);
            check("rst_rsp_rdata", rsp_rdata[g], 32'd0);
            check("rst_rsp_err", 32'(rsp_err[g]), 32'd0);
        end
        @(posedge clk); #1;

        // Give words 0..15 of every instance known contents.
        for (int g = 0; g < N; g++) begin
            for (int w = 0; w < 16; w++) begin
                txn(g, 1'b1, 32'(w * 4), $urandom, 0);
            end
        end

        // Directed sequence at LATENCY=2.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 5);
        txn(0, 1'b0, 32'h13, 32'h0, 0);
        txn(0, 1'b1, 32'h400, 32'h12345678, 1);
        txn(0, 1'b0, 32'h000, 32'h0, 0);

        // Latency extremes.
        txn(1, 1'b1, 32'h24, 32'hA5A5_0001, 0);
        txn(1, 1'b0, 32'h24, 32'h0, 2);
        txn(2, 1'b1, 32'h28, 32'h5A5A_000F, 0);
        txn(2, 1'b0, 32'h28, 32'h0, 2);

        // Reset while a store is still counting down at LATENCY=4.
        txn(3, 1'b0, 32'h20, 32'h0, 0);
        req_valid[3] = 1'b1;
        req_write[3] = 1'b1;
        req_addr[3]  = 32'h20;
        req_wdata[3] = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        check("midwait_busy", 32'(busy[3]), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[3] = 1'b0;
        #1;
        check("midrst_busy", 32'(busy[3]), 32'd0);
        check("midrst_req_ready", 32'(req_ready[3]), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid[3]), 32'd0);
        check("midrst_rdata", rsp_rdata[3], 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n[3] = 1'b1;
        @(posedge clk); #1;
        txn(3, 1'b0, 32'h20, 32'h0, 0);

        // Random traffic on each instance.
        for (int g = 0; g < N; g++) begin
            for (int t = 0; t < 25; t++) begin
                r = int'($urandom_range(0, 9));
                a = 32'($urandom_range(0, 15)) << 2;
                if (r == 0) a = a | 32'($urandom_range(1, 3));
                if (r == 1) a = $urandom | 32'h400;
                txn(g, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
